// File: rtl/line_clear.sv
// Removes completed rows from a settled 20x10 playfield, one row per scan step,
// collapsing everything above each cleared row down by one.
module line_clear (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [199:0] board_in,
  output logic [199:0] board_out,
  output logic [4:0]   lines_cleared,
  output logic         busy,
  output logic         done
);

  localparam int unsigned COLS = 10;
  localparam int unsigned ROWS = 20;
  localparam int unsigned BW   = ROWS * COLS;
  localparam int unsigned RW   = 5;
  localparam int unsigned OW   = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_SHIFT
  } state_t;

  state_t        state_q;
  logic [BW-1:0] work_q;
  logic [RW-1:0] row_q;
  logic [RW-1:0] count_q;
  logic [BW-1:0] board_out_q;
  logic [RW-1:0] lines_q;
  logic          busy_q;
  logic          done_q;

  logic [OW-1:0] row_base_c;
  logic          row_full_c;
  logic [BW-1:0] work_shift_d;

  // Bit offset of the row currently being scanned (max 190).
  always_comb begin
    row_base_c = OW'(row_q) * OW'(COLS);
    row_full_c = &work_q[row_base_c +: COLS];
  end

  // Rows at and above the cleared row drop by one; the top row refills empty.
  always_comb begin
    work_shift_d = work_q;
    for (int unsigned r = 0; r < ROWS - 1; r++) begin
      if (r >= 32'(row_q)) begin
        work_shift_d[r*COLS +: COLS] = work_q[(r+1)*COLS +: COLS];
      end
    end
    work_shift_d[BW-1 -: COLS] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      row_q       <= '0;
      count_q     <= '0;
      board_out_q <= '0;
      lines_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            work_q  <= board_in;
            row_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (row_full_c) begin
            state_q <= S_SHIFT;
          end else if (row_q != RW'(ROWS - 1)) begin
            row_q <= row_q + RW'(1);
          end else begin
            board_out_q <= work_q;
            lines_q     <= count_q;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_SHIFT: begin
          // Row index is kept so the row that just moved down is rechecked.
          work_q  <= work_shift_d;
          count_q <= count_q + RW'(1);
          state_q <= S_SCAN;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign board_out     = board_out_q;
  assign lines_cleared = lines_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_line_clear.sv
// Scoreboard bench for line_clear: stimulus queues expected results, a monitor
// checks them whenever done pulses.
module tb_line_clear;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [199:0] board_in;
  logic [199:0] board_out;
  logic [4:0]   lines_cleared;
  logic         busy;
  logic         done;

  typedef struct {
    logic [199:0] board;
    logic [4:0]   lines;
    int unsigned  fin;
    int unsigned  busy_len;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned busy_cnt = 0;

  line_clear dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .board_in     (board_in),
    .board_out    (board_out),
    .lines_cleared(lines_cleared),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Edge counter: value after an edge is that edge's number.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [199:0] with_row(input logic [199:0] b, input int r, input logic [9:0] v);
    logic [199:0] t;
    t = b;
    t[r*10 +: 10] = v;
    return t;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 200'(done), 200'(0));
      end else begin
        e = sb.pop_front();
        chk("board_out", board_out, e.board);
        chk("lines_cleared", 200'(lines_cleared), 200'(e.lines));
        chk("finish_edge", 200'(cyc), 200'(e.fin));
        chk("busy_in_done", 200'(busy), 200'(0));
        chk("busy_cycles", 200'(busy_cnt), 200'(e.busy_len));
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt = busy_cnt + 1;
    end
  end

  task automatic issue(input logic [199:0] b, input logic [199:0] eb, input logic [4:0] el,
                       input int unsigned lat, output int unsigned e);
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    e        = cyc + 1;
    sb.push_back('{eb, el, e + lat, lat});
    @(negedge clk);
    start    = 1'b0;
    board_in = ~b;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout", 200'(sb.size()), 200'(0));
      sb.delete();
    end
    @(negedge clk);
  endtask

  logic [199:0] b_empty, b_bottom, b_tetris, b_top, b_full, b_mixed, x_mixed;
  int unsigned  e0;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    board_in = '0;

    b_empty  = '0;
    b_bottom = with_row('0, 0, 10'h3FF);
    b_bottom[10] = 1'b1;
    b_tetris = '0;
    for (int r = 0; r < 4; r++) b_tetris = with_row(b_tetris, r, 10'h3FF);
    b_tetris = with_row(b_tetris, 4, 10'h001);
    b_top    = with_row('0, 19, 10'h3FF);
    b_full   = '1;
    b_mixed  = with_row('0, 0, 10'h155);
    b_mixed  = with_row(b_mixed, 2, 10'h3FF);
    b_mixed  = with_row(b_mixed, 3, 10'h200);
    b_mixed  = with_row(b_mixed, 5, 10'h3FF);
    b_mixed  = with_row(b_mixed, 7, 10'h0F0);
    x_mixed  = with_row('0, 0, 10'h155);
    x_mixed  = with_row(x_mixed, 2, 10'h200);
    x_mixed  = with_row(x_mixed, 5, 10'h0F0);

    repeat (2) @(negedge clk);
    chk("rst_board_out", board_out, 200'(0));
    chk("rst_lines", 200'(lines_cleared), 200'(0));
    chk("rst_busy", 200'(busy), 200'(0));
    chk("rst_done", 200'(done), 200'(0));
    rst = 1'b0;

    issue(b_empty, 200'(0), 5'd0, 20, e0);
    chk("busy_after_accept", 200'(busy), 200'(1));
    wait_idle();
    issue(b_bottom, 200'(1), 5'd1, 22, e0);
    wait_idle();
    issue(b_tetris, 200'(1), 5'd4, 28, e0);
    wait_idle();
    issue(b_top, 200'(0), 5'd1, 22, e0);
    wait_idle();
    issue(b_full, 200'(0), 5'd20, 60, e0);
    wait_idle();
    issue(b_mixed, x_mixed, 5'd2, 24, e0);
    wait_idle();

    // Extra start pulse at edge E+3 must be ignored.
    issue(b_bottom, 200'(1), 5'd1, 22, e0);
    while (cyc < e0 + 2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset at edge E+5 aborts the operation without a done pulse.
    @(negedge clk);
    board_in = b_full;
    start    = 1'b1;
    e0       = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 200'(busy), 200'(0));
    chk("abort_board_out", board_out, 200'(0));
    chk("abort_lines", 200'(lines_cleared), 200'(0));
    chk("abort_done", 200'(done), 200'(0));
    repeat (70) @(negedge clk);

    // Start accepted in the done cycle of the previous operation.
    issue(b_empty, 200'(0), 5'd0, 20, e0);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    board_in = b_tetris;
    start    = 1'b1;
    e0       = cyc + 1;
    sb.push_back('{200'(1), 5'd4, e0 + 28, 28});
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 200'(busy), 200'(1));
    wait_idle();
    chk("hold_board_out", board_out, 200'(1));
    chk("hold_lines", 200'(lines_cleared), 200'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
